// File: rtl/mc_sequencer_pkg.sv
// cpu_pkg: opcodes, ALU codes, FSM states and write-back selects shared by the sequencer
package cpu_pkg;
  localparam logic [6:0] OP_NOP = 7'h00, OP_ADD = 7'h01, OP_SUB = 7'h02, OP_AND = 7'h03,
                         OP_OR = 7'h04, OP_ADDI = 7'h05, OP_LOAD = 7'h10, OP_STORE = 7'h11,
                         OP_MOV = 7'h12, OP_HALT = 7'h7f;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_R1 = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       imm_calc;
    logic       reg_out;
    logic [1:0] m2reg;
  } ctrl_t;
endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: datapath-facing control and status bundle of the sequencer
interface mc_sequencer_if #(parameter int CNT_W = 16);
  logic             run, mem_ready;
  logic [6:0]       op;
  logic             pc_en, ir_wr, imm_calc, rg_wr, dmem_rd, dmem_wr, reg_out;
  logic             busy, halted, illegal, timeout;
  logic [2:0]       alu_op, state;
  logic [1:0]       m2reg;
  logic [CNT_W-1:0] retired;
  modport master (
    output run, op, mem_ready,
    input  pc_en, ir_wr, alu_op, imm_calc, rg_wr, dmem_rd, dmem_wr, reg_out, m2reg,
    input  state, busy, halted, illegal, timeout, retired
  );
  modport slave (
    input  run, op, mem_ready,
    output pc_en, ir_wr, alu_op, imm_calc, rg_wr, dmem_rd, dmem_wr, reg_out, m2reg,
    output state, busy, halted, illegal, timeout, retired
  );
endinterface

// File: rtl/mc_sequencer_decode.sv
// mc_decode: combinational opcode decoder producing the control bundle and class flags
module mc_decode
  import cpu_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_halt,
  output logic       is_illegal,
  output logic       is_nop
);
  logic is_alu;
  always_comb begin
    is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI};
    is_load = op == OP_LOAD;
    is_mem = is_load || op == OP_STORE;
    is_halt = op == OP_HALT;
    is_nop = op == OP_NOP;
    is_illegal = !(is_alu || is_mem || is_halt || is_nop || op == OP_MOV);
    ctrl.alu_op = op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
    ctrl.imm_calc = op == OP_ADDI;
    ctrl.reg_out = is_load;
    ctrl.m2reg = is_load ? M2R_MEM : op == OP_MOV ? M2R_R1 : M2R_ALU;
  end
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and retire counter
module mc_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  mc_sequencer_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t st;
  ctrl_t ctrl, dec_ctrl;
  logic d_mem, d_load, d_halt, d_ill, d_nop;
  logic is_mem, is_load, is_nop;
  logic pc_q, ir_q, rg_q, rd_q, wr_q, halted_q, illegal_q, timeout_q;
  logic [WW-1:0] wcnt;
  logic [CNT_W-1:0] retired;
  logic store_done, pc_en;
  mc_decode u_dec (
    .op(bus.op), .ctrl(dec_ctrl), .is_mem(d_mem), .is_load(d_load),
    .is_halt(d_halt), .is_illegal(d_ill), .is_nop(d_nop)
  );
  // a STORE retires in the very MEM cycle its ready arrives, so this strobe cannot be registered
  assign store_done = st == S_MEM && !is_load && bus.mem_ready;
  assign pc_en = pc_q || store_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      ctrl <= '0;
      {is_mem, is_load, is_nop} <= '0;
      {pc_q, ir_q, rg_q, rd_q, wr_q, halted_q, illegal_q, timeout_q} <= '0;
      wcnt <= '0;
      retired <= '0;
    end else begin
      ir_q <= 1'b0;
      pc_q <= 1'b0;
      rg_q <= 1'b0;
      retired <= retired + CNT_W'(pc_en);
      case (st)
        S_IDLE: if (bus.run) begin
          st <= S_FETCH;
          ir_q <= 1'b1;
        end
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          ctrl <= dec_ctrl;
          {is_mem, is_load, is_nop} <= {d_mem, d_load, d_nop};
          if (d_halt || d_ill) begin
            st <= S_HALT;
            halted_q <= 1'b1;
            illegal_q <= d_ill;
          end else begin
            st <= S_EXEC;
            pc_q <= d_nop;
          end
        end
        S_EXEC:
          if (is_mem) begin
            st <= S_MEM;
            {rd_q, wr_q} <= {is_load, !is_load};
            wcnt <= '0;
          end else if (is_nop) begin
            st <= bus.run ? S_FETCH : S_IDLE;
            ir_q <= bus.run;
          end else begin
            st <= S_WB;
            {rg_q, pc_q} <= 2'b11;
          end
        S_MEM:
          if (bus.mem_ready) begin
            {rd_q, wr_q} <= 2'b00;
            if (is_load) begin
              st <= S_WB;
              {rg_q, pc_q} <= 2'b11;
            end else begin
              st <= bus.run ? S_FETCH : S_IDLE;
              ir_q <= bus.run;
            end
          end else if (wcnt == WW'(MEM_TIMEOUT - 1)) begin
            {rd_q, wr_q} <= 2'b00;
            st <= S_HALT;
            {halted_q, timeout_q} <= 2'b11;
          end else
            wcnt <= wcnt + 1'b1;
        S_WB: begin
          st <= bus.run ? S_FETCH : S_IDLE;
          ir_q <= bus.run;
        end
        default: ;
      endcase
    end
  end
  assign bus.pc_en = pc_en;
  assign bus.ir_wr = ir_q;
  assign bus.rg_wr = rg_q;
  assign bus.dmem_rd = rd_q;
  assign bus.dmem_wr = wr_q;
  assign bus.alu_op = ctrl.alu_op;
  assign bus.imm_calc = ctrl.imm_calc;
  assign bus.reg_out = ctrl.reg_out;
  assign bus.m2reg = ctrl.m2reg;
  assign bus.state = st;
  assign bus.busy = st != S_IDLE && st != S_HALT;
  assign bus.halted = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.retired = retired;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scoreboard bench; per-cycle expected traces are queued with stimulus and popped against the DUT
module tb_mc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  mc_sequencer_if #(.CNT_W(16)) bus ();
  mc_sequencer_if #(.CNT_W(2)) bus2 ();
  mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  typedef struct packed {
    logic       run;
    logic [6:0] op;
    logic       rdy;
    logic [2:0] st;
    logic       pc_en, ir_wr, rg_wr, rd, wr;
    logic       ctl;
    logic [2:0] alu;
    logic       imm, ro;
    logic [1:0] m2;
  } rec_t;
  rec_t q[$];
  task automatic push_idle(input logic r);
    rec_t x;
    x = '0;
    x.run = r;
    q.push_back(x);
  endtask
  // waits < 0 means memory never answers
  task automatic push_instr(input logic [6:0] o, input int waits, input logic r);
    rec_t x;
    logic ld, sto, legal;
    ld = o == 7'h10;
    sto = o == 7'h11;
    legal = o inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h10, 7'h11, 7'h12};
    x = '0;
    x.run = 1'b1;
    x.op = o;
    x.st = 3'd1;
    x.ir_wr = 1'b1;
    q.push_back(x);
    x.ir_wr = 1'b0;
    x.st = 3'd2;
    q.push_back(x);
    if (!legal) begin
      x.st = 3'd6;
      q.push_back(x);
      return;
    end
    x.ctl = 1'b1;
    x.alu = o == 7'h02 ? 3'd1 : o == 7'h03 ? 3'd2 : o == 7'h04 ? 3'd3 : 3'd0;
    x.imm = o == 7'h05;
    x.ro = ld;
    x.m2 = ld ? 2'd1 : o == 7'h12 ? 2'd2 : 2'd0;
    x.run = r;
    x.st = 3'd3;
    x.pc_en = o == 7'h00;
    q.push_back(x);
    x.pc_en = 1'b0;
    if (ld || sto) begin
      for (int i = 0; i <= (waits < 0 ? 14 : waits); i++) begin
        x.st = 3'd4;
        x.rdy = waits >= 0 && i == waits;
        x.rd = ld;
        x.wr = sto;
        x.pc_en = sto && x.rdy;
        q.push_back(x);
      end
      {x.rdy, x.rd, x.wr, x.pc_en} = '0;
      if (waits < 0) begin
        x.ctl = 1'b0;
        x.st = 3'd6;
        q.push_back(x);
        return;
      end
    end
    if (o != 7'h00 && !sto) begin
      x.st = 3'd5;
      x.rg_wr = 1'b1;
      x.pc_en = 1'b1;
      q.push_back(x);
    end
  endtask
  task automatic drain(input string name);
    rec_t x;
    while (q.size() > 0) begin
      @(negedge clk);
      x = q.pop_front();
      bus.run = x.run;
      bus.op = x.op;
      bus.mem_ready = x.rdy;
      #1;
      checks++;
      if ({bus.state, bus.pc_en, bus.ir_wr, bus.rg_wr, bus.dmem_rd, bus.dmem_wr} !==
          {x.st, x.pc_en, x.ir_wr, x.rg_wr, x.rd, x.wr}) begin
        failures++;
        $display("FAIL %s trace: got st=%0d pc_en=%b ir_wr=%b rg_wr=%b rd=%b wr=%b, want st=%0d pc_en=%b ir_wr=%b rg_wr=%b rd=%b wr=%b",
                 name, bus.state, bus.pc_en, bus.ir_wr, bus.rg_wr, bus.dmem_rd, bus.dmem_wr,
                 x.st, x.pc_en, x.ir_wr, x.rg_wr, x.rd, x.wr);
      end
      if (x.ctl) begin
        checks++;
        if ({bus.alu_op, bus.imm_calc, bus.reg_out, bus.m2reg} !== {x.alu, x.imm, x.ro, x.m2}) begin
          failures++;
          $display("FAIL %s ctrl: got alu=%0d imm=%b ro=%b m2=%0d, want alu=%0d imm=%b ro=%b m2=%0d",
                   name, bus.alu_op, bus.imm_calc, bus.reg_out, bus.m2reg, x.alu, x.imm, x.ro, x.m2);
        end
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.state, bus.pc_en, bus.ir_wr, bus.alu_op, bus.imm_calc, bus.rg_wr, bus.dmem_rd, bus.dmem_wr,
         bus.reg_out, bus.m2reg, bus.busy, bus.halted, bus.illegal, bus.timeout} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: got st=%0d busy=%b halted=%b, want all zero", bus.state, bus.busy, bus.halted);
    end
    checks++;
    if (bus.retired !== 16'd0 || bus2.retired !== 2'd0) begin
      failures++;
      $display("FAIL reset_retired: got %0d/%0d, want 0/0", bus.retired, bus2.retired);
    end
  endtask
  task automatic test_add_nop();
    push_idle(1'b1);
    push_instr(7'h01, 0, 1'b1);
    push_instr(7'h00, 0, 1'b0);
    push_idle(1'b0);
    drain("add_nop");
    checks++;
    if (bus.retired !== 16'd2) begin
      failures++;
      $display("FAIL add_nop_retired: got %0d, want 2", bus.retired);
    end
  endtask
  task automatic test_load_waits();
    push_idle(1'b1);
    push_instr(7'h10, 3, 1'b0);
    push_idle(1'b0);
    drain("load_waits");
    checks++;
    if (bus.retired !== 16'd3) begin
      failures++;
      $display("FAIL load_retired: got %0d, want 3", bus.retired);
    end
  endtask
  task automatic test_back_to_back();
    push_idle(1'b1);
    push_instr(7'h02, 0, 1'b1);
    push_instr(7'h03, 0, 1'b1);
    push_instr(7'h04, 0, 1'b1);
    push_instr(7'h12, 0, 1'b1);
    push_instr(7'h11, 14, 1'b1);
    push_instr(7'h05, 0, 1'b0);
    push_idle(1'b0);
    drain("back_to_back");
    checks++;
    if (bus.retired !== 16'd9 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_retired: got %0d timeout=%b, want 9 timeout=0", bus.retired, bus.timeout);
    end
  endtask
  task automatic test_run_drop();
    push_idle(1'b1);
    push_instr(7'h05, 0, 1'b0);
    push_idle(1'b0);
    drain("run_drop");
    checks++;
    if (bus.busy !== 1'b0 || bus.imm_calc !== 1'b1 || bus.retired !== 16'd10) begin
      failures++;
      $display("FAIL run_drop_idle: got busy=%b imm=%b retired=%0d, want 0 1 10", bus.busy, bus.imm_calc, bus.retired);
    end
  endtask
  task automatic test_timeout();
    push_idle(1'b1);
    push_instr(7'h11, -1, 1'b1);
    push_idle(1'b1);
    q[q.size()-1].st = 3'd6;
    drain("timeout");
    checks++;
    if ({bus.timeout, bus.halted, bus.illegal, bus.busy} !== 4'b1100 || bus.retired !== 16'd10) begin
      failures++;
      $display("FAIL timeout_status: got to=%b h=%b il=%b busy=%b retired=%0d, want 1 1 0 0 10",
               bus.timeout, bus.halted, bus.illegal, bus.busy, bus.retired);
    end
  endtask
  task automatic test_illegal();
    rec_t x;
    do_reset();
    checks++;
    if ({bus.state, bus.halted, bus.illegal, bus.timeout} !== 6'd0 || bus.retired !== 16'd0) begin
      failures++;
      $display("FAIL illegal_pre_reset: got st=%0d status=%b%b%b, want 0 000", bus.state, bus.halted, bus.illegal, bus.timeout);
    end
    push_idle(1'b1);
    push_instr(7'h20, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      x = '0;
      x.run = i[0];
      x.op = 7'h01;
      x.st = 3'd6;
      q.push_back(x);
    end
    drain("illegal");
    checks++;
    if ({bus.illegal, bus.halted, bus.timeout} !== 3'b110 || bus.retired !== 16'd0) begin
      failures++;
      $display("FAIL illegal_status: got il=%b h=%b to=%b retired=%0d, want 1 1 0 0", bus.illegal, bus.halted, bus.timeout, bus.retired);
    end
    do_reset();
    checks++;
    if ({bus.state, bus.halted, bus.illegal, bus.timeout} !== 6'd0) begin
      failures++;
      $display("FAIL illegal_post_reset: got st=%0d status=%b%b%b, want 0 000", bus.state, bus.halted, bus.illegal, bus.timeout);
    end
  endtask
  task automatic test_reset_mid_mem();
    push_idle(1'b1);
    push_instr(7'h10, 2, 1'b1);
    void'(q.pop_back());
    void'(q.pop_back());
    drain("mid_mem");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.dmem_rd !== 1'b0 || bus.state !== 3'd0 || bus.retired !== 16'd0) begin
      failures++;
      $display("FAIL mid_mem_reset: got rd=%b st=%0d retired=%0d, want 0 0 0", bus.dmem_rd, bus.state, bus.retired);
    end
    rst = 1'b0;
    bus.run = 1'b0;
  endtask
  task automatic test_wrap();
    logic [1:0] want;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus2.run = 1'b1;
    bus2.op = 7'h00;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      want = k == 0 ? 2'd0 : 2'((k - 1) / 3);
      checks++;
      if ({bus2.retired, bus2.pc_en} !== {want, k >= 3 && k % 3 == 0}) begin
        failures++;
        $display("FAIL wrap_cycle%0d: got retired=%0d pc_en=%b, want retired=%0d pc_en=%b",
                 k, bus2.retired, bus2.pc_en, want, k >= 3 && k % 3 == 0);
      end
    end
    bus2.run = 1'b0;
  endtask
  initial begin
    bus.run = 1'b0;
    bus.op = 7'h00;
    bus.mem_ready = 1'b0;
    bus2.run = 1'b0;
    bus2.op = 7'h00;
    bus2.mem_ready = 1'b0;
    test_reset();
    test_add_nop();
    test_load_waits();
    test_back_to_back();
    test_run_drop();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath (8-bit PC, 8×16 register file, 64-word data memory). It replaces single-cycle decode with a registered FSM that walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It issues PC-advance, IR-load, register-write and data-memory strobes, and waits on a data-memory ready handshake with a bounded timeout. It also keeps a retired-instruction counter and latches halt/illegal/timeout status for the testbench and debug logic.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles in MEM before a timeout fault.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high; clears all state and outputs.
- `run` in 1: level; start from IDLE and keep issuing instructions while high.
- `op` in 7: opcode field `ins[15:9]` of the instruction currently addressed by the PC.
- `mem_ready` in 1: data memory has completed the current read/write.
- `pc_en` out 1: one-cycle PC increment strobe.
- `ir_wr` out 1: one-cycle instruction-register load strobe.
- `alu_op` out 3: ALU function.
- `imm_calc` out 1: ALU second operand is the zero-extended `ins[5:0]`.
- `rg_wr` out 1: register-file write strobe.
- `dmem_rd`, `dmem_wr` out 1 each: data-memory request; held until `mem_ready`.
- `reg_out` out 1: write-register select; 0 selects rd, 1 selects rs.
- `m2reg` out 2: write-data select; 0 selects ALU Z, 1 selects memory, 2 selects r1.
- `state` out 3: current FSM state encoding.
- `busy` out 1: high in any state other than IDLE or HALT.
- `halted`, `illegal`, `timeout` out 1 each: sticky status bits.
- `retired` out CNT_W: count of completed instructions.

## Operation
- **Opcodes:**
  - NOP=00h
  - ADD=01h
  - SUB=02h
  - AND=03h
  - OR=04h
  - ADDI=05h
  - LOAD=10h
  - STORE=11h
  - MOV=12h
  - HALT=7Fh
  - Any other value is illegal.
- **ALU codes:** ADD=0, SUB=1, AND=2, OR=3. ADDI uses ALU code ADD with `imm_calc`=1.
- **States:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **Transitions:**
  - IDLE→FETCH when `run`=1.
  - FETCH asserts `ir_wr`, then →DECODE.
  - DECODE registers `op` and the decoded controls, then branches:
    - HALT opcode → HALT state with `halted`=1.
    - Illegal opcode → HALT state with `illegal`=1 and `halted`=1.
    - Otherwise → EXEC.
  - EXEC, by instruction class:
    - ALU ops, ADDI, MOV → WB.
    - LOAD, STORE → MEM.
    - NOP: assert `pc_en`, then go to the boundary state.
  - MEM asserts `dmem_rd` (LOAD) or `dmem_wr` (STORE) every cycle until `mem_ready`:
    - LOAD with `mem_ready` → WB.
    - STORE with `mem_ready` → assert `pc_en`, then go to the boundary state.
  - WB asserts `rg_wr` and `pc_en`, then goes to the boundary state.
- **Boundary state:** FETCH if `run`=1, IDLE if `run`=0. `run` is sampled only at the boundary; dropping it never aborts an instruction.
- **Register controls:**
  - ALU ops and ADDI: `reg_out`=0, `m2reg`=0.
  - LOAD: `reg_out`=1, `m2reg`=1.
  - MOV: `reg_out`=0, `m2reg`=2.
- **Control hold:** decoded controls (`alu_op`, `imm_calc`, `reg_out`, `m2reg`) stay stable from the cycle after DECODE until the instruction ends. Strobes are asserted only in the states listed above.
- **Retired counter:** `retired` increments by 1 on every `pc_en`, and wraps from 2^CNT_W−1 to 0.
- **Memory timeout:** the wait counter resets on entry to MEM. If `mem_ready` stays low for MEM_TIMEOUT consecutive cycles:
  - deassert the request;
  - set `timeout` and `halted`;
  - go to HALT with no `pc_en` and no `rg_wr`.
- **HALT state:** absorbing; only `rst` leaves it.

## Timing
- **Reset value:** `rst` forces all outputs to 0 and `state` to IDLE on the next edge. Reset mid-instruction drops any pending memory request the same edge and does not increment `retired`.
- **Latency with zero-wait memory** (`mem_ready` high on the first MEM cycle):
  - NOP: 3 cycles.
  - ALU ops, ADDI, MOV: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Wait states:** each additional wait cycle adds 1 to LOAD and STORE latency.
- **Simultaneous events:**
  - `mem_ready` arriving on the same cycle the timeout count is reached counts as success.
  - `run` falling during FETCH/DECODE has no effect until the boundary.
- **Single-strobe rule:** `pc_en` and `rg_wr` are never high for more than one cycle per instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants;
  - ALU code constants;
  - state encodings;
  - the `m2reg` select constants.
- `mc_decode` is a combinational sub-module. It maps `op` to the control bundle plus `is_mem`, `is_load`, `is_halt`, `is_illegal` and `is_nop`. `mc_sequencer` registers its outputs in DECODE.

## Test plan
- **ADD then NOP:** `rst`, `run`=1, opcodes 01h then 00h.
  - States 1,2,3,5 then 1,2,3.
  - `rg_wr` high once, `m2reg`=0, `alu_op`=0.
  - `retired`=2 after 7 cycles.
- **LOAD with waits:** opcode 10h, `mem_ready` low for 3 cycles.
  - `dmem_rd` high for 4 cycles.
  - WB then has `reg_out`=1 and `m2reg`=1.
  - Total 8 cycles.
- **STORE timeout:** opcode 11h, `mem_ready` held low.
  - After 15 MEM cycles: `timeout`=1, `halted`=1, state 6.
  - No `pc_en`; `retired` unchanged.
- **Illegal opcode:** opcode 20h.
  - DECODE→HALT with `illegal`=1.
  - `run` toggling has no effect; `rst` returns to IDLE with all status bits 0.
- **Run drop:** deassert `run` during EXEC of ADDI.
  - WB completes with `imm_calc`=1.
  - Next state is IDLE and `busy`=0.
- **Reset mid-MEM and counter wrap:**
  - `rst` during LOAD MEM: `dmem_rd`=0 the next cycle.
  - With `CNT_W`=2, after 4 NOPs `retired`=0.
